// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared encodings and constants for the sequential multiply/divide unit
package mult_div_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int ITERATIONS = DEFAULT_WIDTH;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on unsigned magnitudes
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  // remainder < divisor, so the shifted value fits WIDTH+1 bits and diff's msb is a borrow flag
  always_comb begin
    shifted = {rem_i, bit_i};
    diff = shifted - {1'b0, dvs_i};
    q_o = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: 32-iteration signed Booth multiply / restoring divide into HI/LO
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic signed [WIDTH:0] acc_q;
  logic [WIDTH-1:0] mq_q, b_q, hi_q, lo_q;
  logic qm1_q, neg_quo_q, neg_rem_q, busy_q, done_q, dz_q;
  logic signed [WIDTH:0] b_ext_d, sum_d, acc_sh_d;
  logic [WIDTH-1:0] mq_sh_d, rem_d, quo_d, a_mag_d, b_mag_d;
  logic qbit_d, last_d;
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i(acc_q[WIDTH-1:0]),
    .dvs_i(b_q),
    .bit_i(mq_q[WIDTH-1]),
    .rem_o(rem_d),
    .q_o  (qbit_d)
  );
  // Booth add/sub on a guard-bit accumulator (keeps the most negative multiplicand exact), then shift
  always_comb begin
    b_ext_d = {b_q[WIDTH-1], b_q};
    sum_d = (mq_q[0] & ~qm1_q) ? acc_q - b_ext_d : (~mq_q[0] & qm1_q) ? acc_q + b_ext_d : acc_q;
    acc_sh_d = {sum_d[WIDTH], sum_d[WIDTH:1]};
    mq_sh_d = {sum_d[0], mq_q[WIDTH-1:1]};
    quo_d = {mq_q[WIDTH-2:0], qbit_d};
    a_mag_d = src_a[WIDTH-1] ? -src_a : src_a;
    b_mag_d = src_b[WIDTH-1] ? -src_b : src_b;
    last_d = cnt_q == CW'(WIDTH - 1);
  end
  // control FSM with registered outputs; HI/LO written only when entering DONE from an iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mq_q <= '0;
      b_q <= '0;
      qm1_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          cnt_q <= '0;
          acc_q <= '0;
          qm1_q <= 1'b0;
          busy_q <= 1'b1;
          if (op == OP_MULT) begin
            mq_q <= src_b;
            b_q <= src_a;
            state_q <= MULT;
          end else if (src_b == '0) begin
            done_q <= 1'b1;
            dz_q <= 1'b1;
            state_q <= DONE;
          end else begin
            mq_q <= a_mag_d;
            b_q <= b_mag_d;
            neg_quo_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            neg_rem_q <= src_a[WIDTH-1];
            state_q <= DIV;
          end
        end
        MULT: begin
          acc_q <= acc_sh_d;
          mq_q <= mq_sh_d;
          qm1_q <= mq_q[0];
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            hi_q <= acc_sh_d[WIDTH-1:0];
            lo_q <= mq_sh_d;
            done_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DIV: begin
          acc_q <= {1'b0, rem_d};
          mq_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            lo_q <= neg_quo_q ? -quo_d : quo_d;
            hi_q <= neg_rem_q ? -rem_d : rem_d;
            done_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign div_zero = dz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: table-driven and scoreboarded check of mult_div_seq
module tb_mult_div_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic op = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  always #5 clk = ~clk;
  mult_div_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  typedef struct {
    logic op;
    logic [31:0] a, b, hi, lo;
    logic dz;
    int lat;
  } vec_t;
  vec_t tbl[13];
  vec_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  function automatic vec_t model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl);
    longint sa, sbv, p;
    vec_t r;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    r.op = o; r.a = a; r.b = b; r.dz = 1'b0; r.lat = 33;
    if (o == 1'b0) begin
      p = sa * sbv;
      r.hi = p[63:32]; r.lo = p[31:0];
    end else if (b == 32'h0) begin
      r.hi = ph; r.lo = pl; r.dz = 1'b1; r.lat = 1;
    end else begin
      p = sa / sbv; r.lo = p[31:0];
      p = sa % sbv; r.hi = p[31:0];
    end
    return r;
  endfunction
  task automatic run(input vec_t v, input int glitch);
    vec_t got;
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0; op = ~v.op; src_a = $urandom; src_b = $urandom;
    n = 1; seen = 0;
    while (n <= 50 && !seen) begin
      if (n == 1) check("busy_after_start", busy, 1);
      if (n == 5 && v.lat > 1) check("hilo_hold", {hi, lo}, {cur_hi, cur_lo});
      if (glitch != 0 && n == glitch) begin
        start = 1'b1; op = 1'b1; src_a = $urandom; src_b = $urandom_range(5, 1);
      end
      if (glitch != 0 && n == glitch + 1) start = 1'b0;
      if (done) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no done within 50 cycles (a=%h b=%h)", v.a, v.b);
    end else begin
      got = sb.pop_front();
      check("latency", 64'(n), 64'(got.lat));
      check("hi", hi, got.hi);
      check("lo", lo, got.lo);
      check("div_zero", div_zero, got.dz);
      cur_hi = got.hi; cur_lo = got.lo;
    end
    @(negedge clk);
    check("done_pulse_end", {done, busy, div_zero}, 0);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    tbl[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    tbl[2]  = '{1'b0, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 33};
    tbl[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    tbl[4]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    tbl[5]  = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
    tbl[6]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[7]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    tbl[8]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    tbl[9]  = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
    tbl[10] = '{1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 33};
    tbl[11] = '{1'b1, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 33};
    tbl[12] = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1, 1};
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, div_zero, hi, lo}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 13; i++) run(tbl[i], 0);
    for (int i = 0; i < 6; i++) begin
      logic o;
      logic [31:0] a, b;
      o = i[0];
      a = $urandom;
      b = (i == 5) ? 32'h0 : $urandom;
      run(model(o, a, b, cur_hi, cur_lo), 0);
    end
    run('{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33}, 10);
    repeat (40) @(negedge clk);
    check("glitch_ignored", {busy, done}, 0);
    @(negedge clk);
    start = 1'b1; op = 1'b1; src_a = 32'hFFFFFF9C; src_b = 32'h7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_mid_div", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_state", {busy, done, div_zero, hi, lo}, 0);
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (36) @(negedge clk);
    check("abort_no_result", {busy, done, hi, lo}, 0);
    run(model(1'b1, 32'h9, 32'h0, cur_hi, cur_lo), 0);
    run(model(1'b0, 32'h6, 32'h7, cur_hi, cur_lo), 0);
    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
